// File: rtl/play_time_counter.sv
// Elapsed-play-time peripheral: CPU-controlled seconds counter with run,
// pause, clear and track-length limit, driving a 32-bit display word
// {upper field, binary seconds} plus a write strobe on every change.
module play_time_counter #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int MAX_SEC       = 5999
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        WR,
   input  logic [1:0]  ADDR,
   input  logic [31:0] WDATA,
   output logic [31:0] RDATA,
   output logic [31:0] DO,
   output logic        WE,
   output logic        DONE,
   output logic        IRQ
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [15:0]   MAX_V      = 16'(MAX_SEC);

   localparam logic [1:0] A_CTRL    = 2'd0;
   localparam logic [1:0] A_UPPER   = 2'd1;
   localparam logic [1:0] A_LIMIT   = 2'd2;
   localparam logic [1:0] A_ELAPSED = 2'd3;

   logic          run_reg,     run_next;
   logic          done_reg,    done_next;
   logic          irq_reg,     irq_next;
   logic [PW-1:0] presc_reg,   presc_next;
   logic [15:0]   elapsed_reg, elapsed_next;
   logic [15:0]   upper_reg,   upper_next;
   logic [15:0]   limit_reg,   limit_next;
   logic [31:0]   do_reg;
   logic          we_reg;
   logic          init_reg;

   logic          tick;
   logic [15:0]   inc_val;
   logic          hit;
   logic          ctrl_wr;
   logic [31:0]   disp_word;

   // Upper data bits are not part of any register.
   logic          unused_wdata;
   assign unused_wdata = ^WDATA[31:16];

   assign tick      = run_reg && (presc_reg == PRESC_LAST);
   assign inc_val   = (elapsed_reg >= MAX_V) ? MAX_V : elapsed_reg + 16'd1;
   assign hit       = ((limit_reg != 16'd0) && (inc_val >= limit_reg)) || (inc_val == MAX_V);
   assign ctrl_wr   = WR && (ADDR == A_CTRL);
   assign disp_word = {upper_reg, elapsed_reg};

   // Next-state: prescaler/tick first, then bus writes (CLEAR overrides the tick).
   always_comb begin
      run_next     = run_reg;
      done_next    = done_reg;
      irq_next     = 1'b0;
      presc_next   = presc_reg;
      elapsed_next = elapsed_reg;
      upper_next   = upper_reg;
      limit_next   = limit_reg;

      if (run_reg)
         presc_next = tick ? '0 : presc_reg + 1'b1;

      if (tick) begin
         elapsed_next = inc_val;
         if (hit && !done_reg) begin
            run_next  = 1'b0;
            done_next = 1'b1;
            irq_next  = 1'b1;
         end
      end

      if (ctrl_wr) begin
         if (WDATA[1]) begin
            presc_next   = '0;
            elapsed_next = 16'd0;
            done_next    = 1'b0;
            irq_next     = 1'b0;
            run_next     = WDATA[0];
         end else if (!done_next) begin
            run_next = WDATA[0];
         end
      end

      if (WR && (ADDR == A_UPPER))
         upper_next = WDATA[15:0];
      if (WR && (ADDR == A_LIMIT))
         limit_next = WDATA[15:0];
   end

   // Counter and register state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         run_reg     <= 1'b0;
         done_reg    <= 1'b0;
         irq_reg     <= 1'b0;
         presc_reg   <= '0;
         elapsed_reg <= 16'd0;
         upper_reg   <= 16'd0;
         limit_reg   <= 16'd0;
      end else begin
         run_reg     <= run_next;
         done_reg    <= done_next;
         irq_reg     <= irq_next;
         presc_reg   <= presc_next;
         elapsed_reg <= elapsed_next;
         upper_reg   <= upper_next;
         limit_reg   <= limit_next;
      end
   end

   // Display word follows state one cycle later; strobe on change or first cycle out of reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         do_reg   <= 32'd0;
         we_reg   <= 1'b0;
         init_reg <= 1'b1;
      end else begin
         init_reg <= 1'b0;
         we_reg   <= init_reg || (disp_word != do_reg);
         do_reg   <= disp_word;
      end
   end

   // Combinational register readback.
   always_comb begin
      RDATA = 32'd0;
      case (ADDR)
         A_CTRL:    RDATA = {30'd0, done_reg, run_reg};
         A_UPPER:   RDATA = {16'd0, upper_reg};
         A_LIMIT:   RDATA = {16'd0, limit_reg};
         A_ELAPSED: RDATA = {16'd0, elapsed_reg};
         default:   RDATA = 32'd0;
      endcase
   end

   assign DO   = do_reg;
   assign WE   = we_reg;
   assign DONE = done_reg;
   assign IRQ  = irq_reg;

endmodule

// File: tb/tb_play_time_counter.sv
// Directed bench for play_time_counter with TICKS_PER_SEC=4, MAX_SEC=5.
module tb_play_time_counter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        WR;
   logic [1:0]  ADDR;
   logic [31:0] WDATA;
   logic [31:0] RDATA;
   logic [31:0] DO;
   logic        WE;
   logic        DONE;
   logic        IRQ;

   int total = 0;
   int bad   = 0;
   int we_count  = 0;
   int irq_count = 0;
   int we0, irq0;

   play_time_counter #(.TICKS_PER_SEC(4), .MAX_SEC(5)) dut (
      .CLK(CLK), .RST(RST), .WR(WR), .ADDR(ADDR), .WDATA(WDATA),
      .RDATA(RDATA), .DO(DO), .WE(WE), .DONE(DONE), .IRQ(IRQ)
   );

   always #5 CLK = ~CLK;

   // Pulse counters sampled on each active edge.
   always @(posedge CLK) begin
      if (WE)  we_count  <= we_count + 1;
      if (IRQ) irq_count <= irq_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Write lands on the next posedge; returns 1 time unit after it.
   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge CLK);
      WR = 1'b1; ADDR = a; WDATA = d;
      @(posedge CLK);
      #1;
      WR = 1'b0;
   endtask

   task automatic check_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      ADDR = a;
      #1;
      check(tag, RDATA, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; WR = 1'b0; ADDR = 2'd0; WDATA = 32'd0;

      // Reset / init
      cycles(3);
      check("rst_do", DO, 32'd0);
      check("rst_we", {31'd0, WE}, 32'd0);
      check("rst_done", {31'd0, DONE}, 32'd0);
      @(negedge CLK); RST = 1'b0;
      cycles(1);
      check("init_we_hi", {31'd0, WE}, 32'd1);
      check_rd("init_ctrl", 2'd0, 32'd0);
      cycles(1);
      check("init_we_lo", {31'd0, WE}, 32'd0);

      // Counting
      bus_wr(2'd0, 32'd1);
      we0 = we_count;
      cycles(4);
      check_rd("cnt_el1", 2'd3, 32'd1);
      cycles(8);
      check_rd("cnt_el3", 2'd3, 32'd3);
      cycles(1);
      check("cnt_do3", DO, 32'h0000_0003);
      check("cnt_we3", {31'd0, WE}, 32'd1);
      cycles(1);
      check("cnt_we_pulses", we_count - we0, 32'd3);
      bus_wr(2'd0, 32'd2);

      // Pause / resume
      bus_wr(2'd0, 32'd1);
      cycles(5);
      bus_wr(2'd0, 32'd0);
      check_rd("pause_el1", 2'd3, 32'd1);
      cycles(20);
      check_rd("paused_el1", 2'd3, 32'd1);
      bus_wr(2'd0, 32'd1);
      check_rd("resume_ctrl", 2'd0, 32'd1);
      cycles(1);
      check_rd("resume1_el1", 2'd3, 32'd1);
      cycles(1);
      check_rd("resume2_el2", 2'd3, 32'd2);
      bus_wr(2'd0, 32'd2);

      // Limit
      bus_wr(2'd2, 32'd3);
      bus_wr(2'd0, 32'd1);
      irq0 = irq_count;
      check_rd("lim_reg", 2'd2, 32'd3);
      cycles(12);
      check("lim_irq_hi", {31'd0, IRQ}, 32'd1);
      check("lim_done", {31'd0, DONE}, 32'd1);
      check_rd("lim_el3", 2'd3, 32'd3);
      check_rd("lim_ctrl", 2'd0, 32'd2);
      cycles(1);
      check("lim_irq_lo", {31'd0, IRQ}, 32'd0);
      bus_wr(2'd0, 32'd1);
      check_rd("lim_run_ignored", 2'd0, 32'd2);
      cycles(8);
      check_rd("lim_el_hold", 2'd3, 32'd3);
      check("lim_irq_once", irq_count - irq0, 32'd1);
      bus_wr(2'd0, 32'd3);
      check_rd("restart_el0", 2'd3, 32'd0);
      check("restart_done", {31'd0, DONE}, 32'd0);
      check_rd("restart_ctrl", 2'd0, 32'd1);
      cycles(4);
      check_rd("restart_el1", 2'd3, 32'd1);

      // Collisions: CLEAR+RUN in tick cycle, then RUN=0 in tick cycle
      cycles(3);
      bus_wr(2'd0, 32'd3);
      check_rd("coll_clear_el0", 2'd3, 32'd0);
      check_rd("coll_clear_ctrl", 2'd0, 32'd1);
      cycles(3);
      bus_wr(2'd0, 32'd0);
      check_rd("coll_stop_el1", 2'd3, 32'd1);
      check_rd("coll_stop_ctrl", 2'd0, 32'd0);
      cycles(8);
      check_rd("coll_stop_hold", 2'd3, 32'd1);

      // Limit written at or below elapsed
      bus_wr(2'd2, 32'd1);
      bus_wr(2'd0, 32'd1);
      irq0 = irq_count;
      cycles(4);
      check_rd("lowlim_el2", 2'd3, 32'd2);
      check("lowlim_done", {31'd0, DONE}, 32'd1);
      cycles(1);
      check("lowlim_irq", irq_count - irq0, 32'd1);

      // UPPER field and redundant write
      bus_wr(2'd0, 32'd2);
      bus_wr(2'd1, 32'hABCD_1234);
      cycles(1);
      check("upper_do", DO, 32'h1234_0000);
      check("upper_we", {31'd0, WE}, 32'd1);
      check_rd("upper_rd", 2'd1, 32'h0000_1234);
      cycles(1);
      check("upper_we_lo", {31'd0, WE}, 32'd0);
      we0 = we_count;
      bus_wr(2'd1, 32'h0000_1234);
      cycles(3);
      check("upper_same_no_we", we_count - we0, 32'd0);
      check("upper_same_do", DO, 32'h1234_0000);

      // Saturation at MAX_SEC with no limit
      bus_wr(2'd2, 32'd0);
      bus_wr(2'd0, 32'd1);
      irq0 = irq_count;
      cycles(20);
      check_rd("sat_el5", 2'd3, 32'd5);
      check("sat_done", {31'd0, DONE}, 32'd1);
      check_rd("sat_ctrl", 2'd0, 32'd2);
      cycles(8);
      check_rd("sat_hold", 2'd3, 32'd5);
      check("sat_do", DO, 32'h1234_0005);
      check("sat_irq_once", irq_count - irq0, 32'd1);

      // Asynchronous reset mid-count
      bus_wr(2'd0, 32'd3);
      cycles(6);
      check_rd("pre_rst_el1", 2'd3, 32'd1);
      #1;
      RST = 1'b1;
      check_rd("arst_el", 2'd3, 32'd0);
      check_rd("arst_upper", 2'd1, 32'd0);
      check("arst_do", DO, 32'd0);
      check("arst_done", {31'd0, DONE}, 32'd0);
      @(negedge CLK); RST = 1'b0;
      cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
